multiplier_ctrl: RTL and testbench

//  Sequencer for multiplier_DP, the byte-sliced 32x32 multiplier. Accepts one RV32M multiply (MUL/MULH/MULHSU/MULHU)

---
 rtl/multiplier_ctrl.sv | 142 ++++++++++++++
 tb/tb_multiplier_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_ctrl.sv
// multiplier_ctrl: sequencer for the byte-sliced 32x32 multiplier datapath (multiplier_DP).
// Define MULC_REUSE_EN to enable the operand-reuse shortcut (repeat operands skip straight to DONE).
module multiplier_ctrl #(
  parameter int NPASS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op_A_i,
  input  logic [31:0] op_B_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        reg_A_en_o,
  output logic        reg_B_en_o,
  output logic        AC_en_o,
  output logic        en_pipe_o,
  output logic        mux_B_sel_o,
  output logic        rol_en_o,
  output logic        signed_A_o,
  output logic        signed_B_o,
  output logic        upper_o,
  output logic [1:0]  shift_amount_o,
  output logic        ac_clr_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_DRAIN, S_DONE
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // The pass sequence below is hard-wired to four byte slices.
  if (NPASS != 4) begin : g_npass_check
    $error("multiplier_ctrl: only NPASS=4 is supported");
  end

  state_t     state_q, state_d;
  logic       busy_q, done_q, en_pipe_q, ac_en_q, rot_q;
  logic [1:0] shift_q;
  logic       accept, reuse_hit, sign_a, sign_b;

  assign ready_o = (state_q == S_IDLE) && !flush_i;
  assign accept  = valid_i && ready_o;
  assign sign_a  = (op_i == OP_MULH) || (op_i == OP_MULHSU);
  assign sign_b  = (op_i == OP_MULH);

`ifdef MULC_REUSE_EN
  logic [31:0] last_a_q, last_b_q;
  logic        last_sa_q, last_sb_q, reuse_vld_q;

  // The low word is independent of signedness, so MUL may reuse any stored product.
  assign reuse_hit = reuse_vld_q && (op_A_i == last_a_q) && (op_B_i == last_b_q) &&
                     ((op_i == OP_MUL) || ((sign_a == last_sa_q) && (sign_b == last_sb_q)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_a_q    <= '0;
      last_b_q    <= '0;
      last_sa_q   <= 1'b0;
      last_sb_q   <= 1'b0;
      reuse_vld_q <= 1'b0;
    end else if (flush_i) begin
      reuse_vld_q <= 1'b0;
    end else if (accept && !reuse_hit) begin
      last_a_q    <= op_A_i;
      last_b_q    <= op_B_i;
      last_sa_q   <= sign_a;
      last_sb_q   <= sign_b;
      reuse_vld_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      reuse_vld_q <= 1'b1;
    end
  end
`else
  logic unused_operands;
  assign unused_operands = ^{op_A_i, op_B_i};
  assign reuse_hit       = 1'b0;
`endif

  // NOTE: state_d gets a default before the case so this block never infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = reuse_hit ? S_DONE : S_P0;
      S_P0:    state_d = S_P1;
      S_P1:    state_d = S_P2;
      S_P2:    state_d = S_P3;
      S_P3:    state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_pipe_q <= 1'b0;
      ac_en_q   <= 1'b0;
      rot_q     <= 1'b0;
      shift_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      en_pipe_q <= (state_d inside {S_P0, S_P1, S_P2, S_P3, S_DRAIN});
      ac_en_q   <= (state_d inside {S_P0, S_P1, S_P2, S_P3});
      rot_q     <= (state_d inside {S_P0, S_P1, S_P2});
      case (state_d)
        S_P1:    shift_q <= 2'b01;
        S_P2:    shift_q <= 2'b11;
        S_P3:    shift_q <= 2'b10;
        default: shift_q <= 2'b00;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign en_pipe_o      = en_pipe_q;
  assign AC_en_o        = ac_en_q;
  assign shift_amount_o = shift_q;
  assign mux_B_sel_o    = rot_q;
  assign rol_en_o       = rot_q;

  assign reg_A_en_o = accept;
  assign reg_B_en_o = (accept && !reuse_hit) || rot_q;
  assign ac_clr_o   = accept && !reuse_hit;
  assign signed_A_o = accept && sign_a;
  assign signed_B_o = accept && sign_b;
  assign upper_o    = accept && (op_i != OP_MUL);

endmodule

// File: tb/tb_multiplier_ctrl.sv
// tb_multiplier_ctrl: directed and randomized checks of multiplier_ctrl against a cycle-offset model.
// The model tracks how many cycles have elapsed since the accepting edge and derives every control from that.
module tb_multiplier_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] op_A_i, op_B_i;
  logic        ready_o, busy_o, done_o;
  logic        reg_A_en_o, reg_B_en_o, AC_en_o, en_pipe_o, mux_B_sel_o, rol_en_o;
  logic        signed_A_o, signed_B_o, upper_o, ac_clr_o;
  logic [1:0]  shift_amount_o;

  multiplier_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .op_A_i(op_A_i), .op_B_i(op_B_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
    .reg_A_en_o(reg_A_en_o), .reg_B_en_o(reg_B_en_o), .AC_en_o(AC_en_o), .en_pipe_o(en_pipe_o),
    .mux_B_sel_o(mux_B_sel_o), .rol_en_o(rol_en_o), .signed_A_o(signed_A_o),
    .signed_B_o(signed_B_o), .upper_o(upper_o), .shift_amount_o(shift_amount_o),
    .ac_clr_o(ac_clr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: age = cycles since the accepting edge (0 = idle, 6 = result final).
  int          age = 0;
  bit          rv = 1'b0;
  logic [31:0] last_a = '0, last_b = '0;
  bit          last_sa = 1'b0, last_sb = 1'b0;
  int          shift_code [4] = '{0, 1, 3, 2};

  // Observed DUT events, used for latency and throughput measurement.
  int cyc = 0, n_done = 0, n_acc = 0, acc_cyc = 0, prev_acc_cyc = 0, done_cyc = 0;

  task automatic cycle();
    bit acc, hit, sa, sb, rot;
    logic [2:0] exp_load, exp_sign;
    logic [5:0] exp_pass;
    logic [1:0] sh;
    @(negedge clk_i);
    sa  = (op_i == 2'd1) || (op_i == 2'd2);
    sb  = (op_i == 2'd1);
    acc = (age == 0) && !flush_i && valid_i;
`ifdef MULC_REUSE_EN
    hit = rv && (op_A_i == last_a) && (op_B_i == last_b) &&
          ((op_i == 2'd0) || ((sa == last_sa) && (sb == last_sb)));
`else
    hit = 1'b0;
`endif
    rot = (age >= 1) && (age <= 3);
    sh  = (age >= 1 && age <= 4) ? 2'(shift_code[age-1]) : 2'd0;
    exp_load = {acc, (acc && !hit) || rot, acc && !hit};
    exp_sign = {acc && sa, acc && sb, acc && (op_i != 2'd0)};
    exp_pass = {(age >= 1 && age <= 5), (age >= 1 && age <= 4), rot, rot, sh};
    check("ready", ready_o, (age == 0) && !flush_i);
    check("busy", busy_o, age != 0);
    check("done", done_o, age == 6);
    check("load", {reg_A_en_o, reg_B_en_o, ac_clr_o}, exp_load);
    check("sign", {signed_A_o, signed_B_o, upper_o}, exp_sign);
    check("pass", {en_pipe_o, AC_en_o, mux_B_sel_o, rol_en_o, shift_amount_o}, exp_pass);
    if (valid_i && ready_o) begin
      prev_acc_cyc = acc_cyc;
      acc_cyc = cyc;
      n_acc++;
    end
    if (done_o) begin
      done_cyc = cyc;
      n_done++;
    end
    if (flush_i) begin
      age = 0;
      rv  = 1'b0;
    end else if (acc) begin
      if (hit) age = 6;
      else begin
        age = 1;
        rv = 1'b0;
        last_a = op_A_i; last_b = op_B_i; last_sa = sa; last_sb = sb;
      end
    end else if (age == 6) begin
      age = 0;
      rv  = 1'b1;
    end else if (age != 0) begin
      age++;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic set_in(input bit v, input bit f, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    valid_i = v; flush_i = f; op_i = op; op_A_i = a; op_B_i = b;
  endtask

  // Offers one op, then waits (bounded) for done; lat = -1 if done never came.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int d0;
    set_in(1'b1, 1'b0, op, a, b);
    cycle();
    valid_i = 1'b0;
    d0 = n_done;
    for (int i = 0; i < 20 && n_done == d0; i++) cycle();
    lat = (n_done == d0) ? -1 : done_cyc - acc_cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, a0;
    rst_i = 1'b1;
    set_in(1'b0, 1'b0, 2'd0, '0, '0);
    cycle();
    rst_i = 1'b0;
    cycle();

    // MUL 7 x -3: full sequence, shift codes checked each pass by the model.
    run_op(2'd0, 32'd7, 32'hFFFF_FFFD, lat);
    check("mul_latency", lat, 6);

    // Reset while in P2 aborts with no done pulse.
    set_in(1'b1, 1'b0, 2'd1, 32'h8000_0000, 32'h8000_0000);
    cycle();
    valid_i = 1'b0;
    cycle();
    cycle();
    d0 = n_done;
    rst_i = 1'b1; age = 0; rv = 1'b0;
    cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("rst_no_done", n_done - d0, 0);

    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, lat);
    check("mulh_latency", lat, 6);
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("mulhu_latency", lat, 6);

    // valid_i held high: second accept exactly 7 cycles after the first.
    set_in(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    a0 = n_acc;
    for (int i = 0; i < 30 && n_acc - a0 < 2; i++) cycle();
    check("b2b_gap", (n_acc - a0 >= 2) ? acc_cyc - prev_acc_cyc : -1, 7);
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // Flush in P1, then flush with valid in IDLE.
    set_in(1'b1, 1'b0, 2'd0, 32'd3, 32'd5);
    cycle();
    valid_i = 1'b0;
    cycle();
    d0 = n_done;
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("flush_no_done", n_done - d0, 0);
    a0 = n_acc;
    set_in(1'b1, 1'b1, 2'd0, 32'd3, 32'd5);
    cycle();
    check("flush_blocks_accept", n_acc - a0, 0);
    run_op(2'd0, 32'd3, 32'd5, lat);
    check("mul_after_flush", lat, 6);

    // Same operands twice: shortcut only when the reuse option is built in.
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    check("reuse_first", lat, 6);
    run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, lat);
`ifdef MULC_REUSE_EN
    check("reuse_hit", lat, 1);
`else
    check("reuse_off", lat, 6);
`endif
    run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF1, lat);
    check("reuse_newb", lat, 6);

    // Randomized traffic with occasional flush, reset and repeated operands.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; age = 0; rv = 1'b0;
      end else begin
        rst_i   = 1'b0;
        valid_i = 1'($urandom_range(0, 1));
        flush_i = ($urandom_range(0, 15) == 0);
        op_i    = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) begin
          op_A_i = last_a; op_B_i = last_b;
        end else begin
          op_A_i = $urandom; op_B_i = $urandom;
        end
      end
      cycle();
    end
    rst_i = 1'b0;
    set_in(1'b0, 1'b0, 2'd0, '0, '0);
    for (int i = 0; i < 8; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
